// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache in front of inst_memory.
// Hits respond one cycle after acceptance. A miss fetches the whole enclosing block,
// waits MISS_LATENCY cycles, fills the line and returns the requested word.
// Optional feature macro: ICACHE_STATS_EN adds hit/miss counters (o_hit_count, o_miss_count).
module inst_cache #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned BLOCK_SIZE   = 16,
    parameter int unsigned LINES        = 8,
    parameter int unsigned MISS_LATENCY = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_req_valid,
    input  logic [WORD_SIZE-1:0]            i_req_ptr,
    output logic                            o_req_ready,
    input  logic                            i_flush,
    output logic                            o_resp_valid,
    output logic [WORD_SIZE-1:0]            o_resp_inst,
    output logic                            o_mem_req,
    output logic [WORD_SIZE-1:0]            o_mem_ptr,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] i_mem_block
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                     o_hit_count,
    output logic [31:0]                     o_miss_count
`endif
);

    localparam int unsigned OB  = $clog2(BLOCK_SIZE);
    localparam int unsigned IB  = $clog2(LINES);
    localparam int unsigned TW  = WORD_SIZE - OB - IB;
    localparam int unsigned CW  = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [LINES-1:0]       r_valid;
    logic                   r_flush_pend;
    logic [WORD_SIZE-1:0]   r_ptr;
    logic [TW-1:0]          r_tag  [LINES];
    logic [WORD_SIZE-1:0]   r_data [LINES][BLOCK_SIZE];

    logic [OB-1:0]          w_req_off;
    logic [IB-1:0]          w_req_idx;
    logic [TW-1:0]          w_req_tag;
    logic [OB-1:0]          w_ptr_off;
    logic [IB-1:0]          w_ptr_idx;
    logic [TW-1:0]          w_ptr_tag;
    logic                   w_hit;
    logic                   w_flush_eff;
    logic                   w_accept;
    logic                   w_fill;
    logic [WORD_SIZE-1:0]   w_blk_words [BLOCK_SIZE];

    assign w_req_off = i_req_ptr[OB-1:0];
    assign w_req_idx = i_req_ptr[OB+IB-1:OB];
    assign w_req_tag = i_req_ptr[WORD_SIZE-1:OB+IB];
    assign w_ptr_off = r_ptr[OB-1:0];
    assign w_ptr_idx = r_ptr[OB+IB-1:OB];
    assign w_ptr_tag = r_ptr[WORD_SIZE-1:OB+IB];

    // A flush seen during WAIT is held and applied on the first IDLE edge, where it
    // blocks acceptance exactly like a live flush so no hit can use a stale line.
    assign w_flush_eff = i_flush | r_flush_pend;
    assign o_req_ready = (r_state == StIdle) && !w_flush_eff;
    assign w_accept    = o_req_ready && i_req_valid;
    assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_fill      = (r_state == StWait) && (r_cnt == '0) && !i_reset;

    // Unpack the memory block; word offset 0 lives in the MSBs.
    always_comb begin
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            w_blk_words[k] = i_mem_block[WORD_SIZE*(BLOCK_SIZE-k)-1 -: WORD_SIZE];
        end
    end

    // Control FSM with registered response and memory-request outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_ptr        <= '0;
            o_resp_valid <= 1'b0;
            o_resp_inst  <= '0;
            o_mem_req    <= 1'b0;
            o_mem_ptr    <= '0;
        end else begin
            o_resp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_flush_eff) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (w_accept) begin
                        if (w_hit) begin
                            o_resp_inst  <= r_data[w_req_idx][w_req_off];
                            o_resp_valid <= 1'b1;
                        end else begin
                            r_ptr     <= i_req_ptr;
                            o_mem_ptr <= {i_req_ptr[WORD_SIZE-1:OB], {OB{1'b0}}};
                            o_mem_req <= 1'b1;
                            r_cnt     <= CW'(MISS_LATENCY - 1);
                            r_state   <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (i_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_valid[w_ptr_idx] <= 1'b1;
                        o_resp_inst        <= w_blk_words[w_ptr_off];
                        o_resp_valid       <= 1'b1;
                        o_mem_req          <= 1'b0;
                        r_state            <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Line data and tag storage; written only on the fill edge, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_tag[w_ptr_idx] <= w_ptr_tag;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                r_data[w_ptr_idx][k] <= w_blk_words[k];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Accepted hit/miss counters, wrapping modulo 2^32.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                o_hit_count <= o_hit_count + 32'd1;
            end else begin
                o_miss_count <= o_miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: scoreboard of expected responses (data and due cycle),
// a block-memory model driven from o_mem_ptr, and immediate-assertion checks.
module tb_inst_cache;

    localparam int unsigned WS = 32;
    localparam int unsigned BS = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [WS-1:0]     req_ptr;
    logic              req_ready;
    logic              flush;
    logic              resp_valid;
    logic [WS-1:0]     resp_inst;
    logic              mem_req;
    logic [WS-1:0]     mem_ptr;
    logic [WS*BS-1:0]  mem_block;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    inst_cache #(
        .WORD_SIZE   (WS),
        .BLOCK_SIZE  (BS),
        .LINES       (8),
        .MISS_LATENCY(4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_ptr   (req_ptr),
        .o_req_ready (req_ready),
        .i_flush     (flush),
        .o_resp_valid(resp_valid),
        .o_resp_inst (resp_inst),
        .o_mem_req   (mem_req),
        .o_mem_ptr   (mem_ptr),
        .i_mem_block (mem_block)
`ifdef ICACHE_STATS_EN
        ,
        .o_hit_count (hit_count),
        .o_miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [WS-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WS-1:0] mem_word(input logic [WS-1:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    // Memory model: block at mem_ptr, offset 0 in the MSBs.
    always_comb begin
        for (int k = 0; k < BS; k++) begin
            mem_block[WS*(BS-k)-1 -: WS] = mem_word(mem_ptr + 32'(k));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every response must match the oldest expectation in data and cycle.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_resp", 64'(resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_data", 64'(resp_inst), 64'(e.data));
                chk("resp_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; hit selects the expected latency (1 or MISS_LATENCY+1).
    task automatic req(input logic [WS-1:0] a, input bit hit);
        int t;
        req_valid = 1'b1;
        req_ptr   = a;
        #1;
        t = 0;
        while (!req_ready && t < 20) begin
            tick();
            #1;
            t++;
        end
        chk("req_ready", 64'(req_ready), 64'd1);
        q.push_back('{data: mem_word(a), due: cyc + (hit ? 1 : 5)});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 30) begin
            tick();
            t++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_ptr   = '0;
        flush     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_inst", 64'(resp_inst), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_ptr", 64'(mem_ptr), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        tick();

        // Miss on 0x23: block request held for four cycles, then response
        req(32'h23, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("miss_mem_req", 64'(mem_req), 64'd1);
            chk("miss_mem_ptr", 64'(mem_ptr), 64'h20);
        end
        @(negedge clk);
        chk("fill_mem_req_low", 64'(mem_req), 64'd0);
        wait_drain();

        // Sixteen back-to-back hits across the filled line
        for (int i = 0; i < 16; i++) begin
            req(32'h20 + 32'(i), 1'b1);
            chk("hit_no_mem_req", 64'(mem_req), 64'd0);
        end
        wait_drain();

        // Same index, different tag: replacement and re-miss
        req(32'hA5, 1'b0);
        wait_drain();
        req(32'hA0, 1'b1);
        req(32'h20, 1'b0);
        wait_drain();
        req(32'h21, 1'b1);
        wait_drain();

        // Flush concurrent with a request: not accepted, line invalidated
        req_valid = 1'b1;
        req_ptr   = 32'h20;
        flush     = 1'b1;
        #1;
        chk("flush_ready", 64'(req_ready), 64'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        req(32'h2C, 1'b0);
        wait_drain();

        // Reset on the second WAIT cycle aborts the fill
        req(32'h35, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_mem_req", 64'(mem_req), 64'd0);
        req(32'h35, 1'b0);
        wait_drain();
        req(32'h3F, 1'b1);
        wait_drain();

        // Flush during WAIT: response still issues, flush lands afterwards
        req(32'h44, 1'b0);
        wait_drain();
        req(32'h57, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain();
        req(32'h44, 1'b0);
        wait_drain();
        req(32'h57, 1'b0);
        wait_drain();

        // One miss then fifteen hits after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req(32'h60, 1'b0);
        for (int i = 1; i < 16; i++) begin
            req(32'h60 + 32'(i), 1'b1);
        end
        wait_drain();
`ifdef ICACHE_STATS_EN
        chk("hit_count", 64'(hit_count), 64'd15);
        chk("miss_count", 64'(miss_count), 64'd1);
`endif

        repeat (3) tick();
        chk("final_queue", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the fetch stage and `inst_memory`. Fetch presents word addresses. Hits return the instruction one cycle after acceptance. A miss requests the enclosing 16-word block from `inst_memory`, waits a fixed miss penalty, fills the line and returns the requested word. This block is the consumer side of the block-read interface that `inst_memory` exports through `ptr`/`out_block`.

## Interface
- `WORD_SIZE`, 32: instruction/address width.
- `BLOCK_SIZE`, 16: words per line; power of two.
- `LINES`, 8: cache lines; power of two, ≥2.
- `MISS_LATENCY`, 4: cycles from miss acceptance to fill edge; ≥1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: fetch request present.
- `req_ptr` in WORD_SIZE: word address of instruction.
- `req_ready` out 1: request accepted this cycle if `req_valid`.
- `flush` in 1: invalidate all lines.
- `resp_valid` out 1: one-cycle pulse, `resp_inst` valid.
- `resp_inst` out WORD_SIZE: returned instruction.
- `mem_req` out 1: high while a line fill is outstanding.
- `mem_ptr` out WORD_SIZE: block-aligned word address to `inst_memory`.
- `mem_block` in WORD_SIZE*BLOCK_SIZE: block from `inst_memory`. Word offset 0 sits in the MSBs `[WORD_SIZE*BLOCK_SIZE-1 -: WORD_SIZE]`; offset k sits at `[WORD_SIZE*(BLOCK_SIZE-k)-1 -: WORD_SIZE]`.

## Operation
- Address split:
  - offset = `req_ptr[OB-1:0]`, with OB = $clog2(BLOCK_SIZE).
  - index = next $clog2(LINES) bits.
  - tag = remaining upper bits.
- Storage per line: valid bit, tag, BLOCK_SIZE words.
- States:
  - IDLE
  - WAIT
- `req_ready` is 1 in IDLE with `flush`=0, and 0 otherwise.
- IDLE, accept (`req_valid && req_ready`):
  - Hit (valid && tag match): `resp_inst` <= line word[offset], `resp_valid` <= 1. Stay IDLE; back-to-back hits are accepted every cycle.
  - Miss: latch `req_ptr`. `mem_ptr` <= `req_ptr` with offset bits zeroed. `mem_req` <= 1. `cnt` <= MISS_LATENCY-1. Go to WAIT.
- WAIT:
  - Each edge with `cnt`≠0: `cnt` decrements.
  - Edge with `cnt`=0:
    - Write `mem_block` into the line; set valid and tag.
    - `resp_inst` <= `mem_block` word[latched offset]. `resp_valid` <= 1.
    - `mem_req` <= 0. Go to IDLE.
- `mem_ptr` holds stable throughout WAIT.
- `resp_valid` deasserts the cycle after any pulse unless a new hit is accepted. There is no response backpressure.
- `flush` in IDLE clears all valid bits at the edge; a concurrent `req_valid` is not accepted.
- `flush` in WAIT is deferred: it is applied at the first IDLE edge, the flushed line included, and the response still issues.
- A miss to the same index replaces the line; there is no eviction write-back.

## Timing
- Hit latency: `resp_valid` high in the cycle after the accepting edge.
- Miss latency: `resp_valid` high MISS_LATENCY+1 cycles after the cycle in which the request was accepted.
- `mem_block` is sampled only on the fill edge.
- Reset values:
  - State IDLE, `cnt`=0, all valid bits 0.
  - `resp_valid`=0, `resp_inst`=0.
  - `mem_req`=0, `mem_ptr`=0.
  - `req_ready` is 1 in the first cycle after reset.
- Reset mid-miss aborts the fill: no line is written and no response issues.
- Line data and tags need no reset.

## Configuration
- `ICACHE_STATS_EN` defined adds two outputs:
  - `hit_count` (32): increments on each accepted hit.
  - `miss_count` (32): increments on each accepted miss.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: both ports and the counters are absent. Functional behaviour is identical either way.

## Test plan
- Reset, then `req_ptr`=0x23 → miss:
  - `mem_req`=1, `mem_ptr`=0x20 for 4 cycles.
  - `resp_valid` pulse with `resp_inst` = `mem_block` offset-3 word, 5 cycles after accept.
- Fill line for 0x20, then requests 0x20..0x2F on consecutive cycles → 16 consecutive `resp_valid` pulses, 1-cycle latency, correct words; `mem_req` stays 0.
- Fill 0x20, then request 0xA0 (same index, different tag) → miss and refill; a following 0x20 misses again.
- Fill 0x20, `flush`=1 together with `req_valid` → `req_ready`=0; the next request to 0x20 misses.
- `reset` asserted on the second WAIT cycle of a miss → the next cycle is IDLE, `resp_valid`=0, `mem_req`=0, and the same address misses afresh.
- With `ICACHE_STATS_EN`: 1 miss followed by 15 hits → `hit_count`=15, `miss_count`=1.
